// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Round-robin arbiter and sequencer that lets four requesters share a single
//   4-bit Gray-to-binary converter. One requester is granted, its Gray word is
//   latched and converted, and the binary result is returned tagged with the
//   requester id.
//
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   [NREQ]    per-requester request
//   gin   in   [4*NREQ]  packed Gray words, gin[4i+3:4i] for requester i
//   gnt   out  [NREQ]    one-hot grant, high for the single LOAD cycle
//   busy  out            high in LOAD, CONV and DONE
//   done  out            one-cycle pulse, b and rid valid while high
//   b     out  [4]       registered binary result
//   rid   out  [2]       id of the requester owning b
//   cnt   out  [CNTW]    completed-conversion count, wraps

// gray2bin_mux
//   Mux-based combinational Gray-to-binary converter.
//   g_i  in   [4]  Gray word
//   b_o  out  [4]  binary word
module gray2bin_mux (
   input  logic [3:0] g_i,
   output logic [3:0] b_o
);
   logic b3, b2, b1, b0;

   // each binary bit selects g or ~g depending on the next higher binary bit
   assign b3  = g_i[3];
   assign b2  = b3 ? ~g_i[2] : g_i[2];
   assign b1  = b2 ? ~g_i[1] : g_i[1];
   assign b0  = b1 ? ~g_i[0] : g_i[0];
   assign b_o = {b3, b2, b1, b0};
endmodule

module gray_conv_arbiter #(
   parameter int NREQ = 4,
   parameter int CNTW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] gin,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              done,
   output logic [3:0]        b,
   output logic [1:0]        rid,
   output logic [CNTW-1:0]   cnt
);

   // state | meaning
   // IDLE  | waiting for any req; arbitrate from ptr upward
   // LOAD  | gnt high for sel; latch the selected Gray word
   // CONV  | converter output captured into b, sel into rid
   // DONE  | done pulse; bump cnt, move ptr past the served requester
   typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

   state_t            state_q;
   logic [1:0]        ptr_q;
   logic [1:0]        sel_q;
   logic [3:0]        greg_q;
   logic [NREQ-1:0]   gnt_q;
   logic              busy_q;
   logic              done_q;
   logic [3:0]        b_q;
   logic [1:0]        rid_q;
   logic [CNTW-1:0]   cnt_q;

   logic [1:0]        sel_d;
   logic              found_d;
   logic [1:0]        idx;
   logic [3:0]        conv_b;

   // first set request at or after ptr, wrapping modulo 4
   always_comb begin
      sel_d   = ptr_q;
      found_d = 1'b0;
      idx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found_d && req[idx]) begin
            sel_d   = idx;
            found_d = 1'b1;
         end
      end
   end

   gray2bin_mux u_conv (
      .g_i (greg_q),
      .b_o (conv_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         greg_q  <= 4'd0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         b_q     <= 4'd0;
         rid_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  sel_q   <= sel_d;
                  gnt_q   <= NREQ'(1) << sel_d;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               greg_q  <= gin[4*sel_q +: 4];
               gnt_q   <= '0;
               state_q <= CONV;
            end
            CONV: begin
               b_q     <= conv_b;
               rid_q   <= sel_q;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= cnt_q + CNTW'(1);
               ptr_q   <= sel_q + 2'd1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign done = done_q;
   assign b    = b_q;
   assign rid  = rid_q;
   assign cnt  = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'd0;
   logic [15:0] gin = 16'd0;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [3:0]  b;
   logic [1:0]  rid;
   logic [7:0]  cnt;

   gray_conv_arbiter #(.NREQ(4), .CNTW(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gin  (gin),
      .gnt  (gnt),
      .busy (busy),
      .done (done),
      .b    (b),
      .rid  (rid),
      .cnt  (cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // transaction-level reference: one service occupies edges k..k+3
   int         t = 0;
   int         mk = 0;
   int         mid = 0;
   int         mptr = 0;
   int         mcnt = 0;
   bit         active = 0;
   logic [3:0] mg = 0;
   logic [3:0] mb = 0;
   logic [1:0] mrid = 0;
   int         done_ids[$];

   function automatic logic [3:0] g2b(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      active = 0; mptr = 0; mcnt = 0; mb = 0; mrid = 0; mg = 0;
   endtask

   task automatic model_edge();
      t++;
      if (rst) begin
         model_reset();
      end else if (!active) begin
         if (req != 0) begin
            for (int i = 0; i < 4; i++) begin
               if (!active && req[(mptr + i) % 4]) begin
                  mid    = (mptr + i) % 4;
                  active = 1;
                  mk     = t;
               end
            end
         end
      end else begin
         if (t == mk + 1) mg = gin[4*mid +: 4];
         if (t == mk + 2) begin
            mb   = g2b(mg);
            mrid = 2'(mid);
         end
         if (t == mk + 3) begin
            mcnt   = (mcnt + 1) % 256;
            mptr   = (mid + 1) % 4;
            active = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] eg;
      eg = (active && t == mk) ? (4'b0001 << mid) : 4'b0000;
      chk("gnt", gnt, eg);
      chk("busy", busy, active);
      chk("done", done, active && (t == mk + 2));
      chk("b", b, mb);
      chk("rid", rid, mrid);
      chk("cnt", cnt, mcnt);
      chk("gnt_onehot", ($countones(gnt) <= 1), 1);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (done) done_ids.push_back(int'(rid));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      bit seen;

      // reset and single request from id 1
      do_reset();
      chk("rst_cnt", cnt, 0);
      gin = 16'h00B0;
      req = 4'b0010;
      step();
      chk("t1_gnt", gnt, 4'b0010);
      step();
      step();
      chk("t1_done", done, 1);
      chk("t1_b", b, 4'b1101);
      chk("t1_rid", rid, 1);
      req = 4'b0000;
      step();
      chk("t1_cnt", cnt, 1);

      // all four requesting, round-robin order from reset pointer
      do_reset();
      done_ids.delete();
      gin = 16'hB840;
      req = 4'b1111;
      for (int i = 0; i < 22; i++) step();
      chk("rr_ndone", done_ids.size(), 5);
      if (done_ids.size() >= 5) begin
         chk("rr_0", done_ids[0], 0);
         chk("rr_1", done_ids[1], 1);
         chk("rr_2", done_ids[2], 2);
         chk("rr_3", done_ids[3], 3);
         chk("rr_4", done_ids[4], 0);
      end

      // id 2 drops req and changes its word right after the grant
      do_reset();
      gin = 16'h0A00;
      req = 4'b0100;
      seen = 0;
      n = 0;
      while (!seen && n < 8) begin
         step();
         n++;
         if (gnt[2]) seen = 1;
      end
      chk("t3_gnt_seen", seen, 1);
      step();
      req = 4'b0000;
      gin = 16'h0500;
      seen = 0;
      n = 0;
      while (!seen && n < 8) begin
         step();
         n++;
         if (done) seen = 1;
      end
      chk("t3_done_seen", seen, 1);
      chk("t3_b", b, g2b(4'hA));
      chk("t3_rid", rid, 2);

      // reset asserted during CONV
      do_reset();
      gin = 16'h0070;
      req = 4'b0010;
      step();
      step();
      req = 4'b0000;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("t4_busy", busy, 0);
      chk("t4_cnt", cnt, 0);
      done_ids.delete();
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("t4_nodone", done_ids.size(), 0);
      req = 4'b1111;
      step();
      chk("t4_ptr0", gnt, 4'b0001);
      req = 4'b0000;
      for (int i = 0; i < 4; i++) step();

      // counter wrap after 256 conversions
      do_reset();
      req = 4'b1111;
      for (int i = 1; i <= 1024; i++) begin
         gin = 16'($urandom);
         step();
         if (i == 1023) chk("wrap_255", cnt, 255);
      end
      chk("wrap_0", cnt, 0);

      // idle stretch
      req = 4'b0000;
      for (int i = 0; i < 24; i++) step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req = 4'b0000;
         gin = 16'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit Gray-to-binary converter among NREQ requesters.
- The converter is the lab's mux-based combinational unit, instantiated unchanged.
- Each requester presents a 4-bit Gray word and raises req; the block grants one requester, latches its word, runs the conversion, then returns the binary result tagged with the requester id.
- Sits between Gray-coded sources (counters, encoders) and binary consumers.

Parameters:
- NREQ, 4, number of requesters; only 4 supported; id width fixed at 2.
- CNTW, 8, width of the completed-conversion counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-requester request; bit i belongs to requester i.
- gin  input  16  packed Gray words; gin[4i+3:4i] belongs to requester i.
- gnt  output  4  one-hot grant; high for the single LOAD cycle.
- busy  output  1  high in LOAD, CONV and DONE.
- done  output  1  one-cycle pulse; b and rid valid while high.
- b  output  4  registered binary result.
- rid  output  2  id of the requester that owns b.
- cnt  output  CNTW  count of completed conversions; wraps.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: FSM=IDLE, gnt=0, busy=0, done=0, b=0, rid=0, cnt=0, rr pointer=0.
- Reset asserted in any state forces these values immediately. A conversion in progress is abandoned, no done is issued, and cnt is not incremented.

FSM states: IDLE -> LOAD -> CONV -> DONE -> IDLE.
- IDLE: if req!=0, select the first set bit searching from ptr upward, modulo 4. Register sel_id and go to LOAD. If req==0, stay in IDLE.
- LOAD: gnt[sel_id]=1. Latch gin[4*sel_id+3 : 4*sel_id] into greg, then go to CONV.
- CONV: greg drives the converter. Capture its output into b and sel_id into rid, then go to DONE.
- DONE: done=1 for exactly one cycle. cnt<=cnt+1, wrapping at 2^CNTW. ptr<=sel_id+1 mod 4. Go to IDLE.

Latency: req sampled at edge k -> gnt high in cycle k+1 -> done high in cycle k+3 -> back in IDLE at k+4. Back-to-back service costs 4 cycles per conversion.

Handshake and boundary rules:
- A requester holds req and its gin word until it sees gnt. After LOAD, later changes to req or gin have no effect on that conversion.
- If req drops before the IDLE sample, that requester is not served. If req drops after the grant, the conversion still completes and done is issued.
- If a requester still has req high after its done, it is re-arbitrated at the next IDLE. Round-robin places it last among current requesters.
- b and rid hold their values after done until the next CONV capture.
- gnt is one-hot or zero; it is never multi-hot.
- Conversion rule: b[3]=g[3], b[i]=b[i+1]^g[i].

Test Plan:
- Reset, then req=4'b0010 with gin[7:4]=4'b1011 -> gnt=4'b0010 at k+1; done at k+3 with b=4'b1101, rid=1; cnt=1.
- req=4'b1111 held, gin words 0000/0100/1000/1011 for ids 0..3 -> done sequence rid 0,1,2,3,0 with b 0000,0111,1111,1101,0000; done every 4 cycles.
- Requester 2 drops req and changes gin the cycle after gnt -> done still issued with b for the latched word.
- rst asserted during CONV -> all outputs 0 immediately; no done pulse; cnt unchanged at 0; ptr=0.
- 256 serviced conversions -> cnt wraps from 255 to 0 on the 256th done.
- req=0 for 20 cycles -> busy=0, gnt=0, done=0 throughout.
